// File: rtl/nmr_seq_pkg.sv
// Shared types and default widths for the NMR acquisition sequencers.
// State encoding is common so selectors and debug taps decode it consistently.
package nmr_seq_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_PRE,
    ST_ACQ,
    ST_GAP,
    ST_FIN
  } seq_state_e;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// tc_o is high in the last cycle of a phase loaded with a value >= 1.
module seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/n_acq_seq.sv
// Per-echo acquisition sequencer: receiver reset pulse, pre-delay, then N windows.
// All outputs are registered copies of the next-state decode; abort/reset win over everything.
module n_acq_seq
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rst_len,
  input  logic [CNT_W-1:0] pre_dly,
  input  logic [CNT_W-1:0] acq_len,
  input  logic [CNT_W-1:0] echo_period,
  input  logic [NUM_W-1:0] echo_num,
  output logic             n_acq_start,
  output logic             n_rst_n,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] echo_idx
);

  seq_state_e state_q, state_d;

  logic [CNT_W-1:0] pre_q, acq_q, gap_q;
  logic [NUM_W-1:0] num_q, idx_q, idx_d;
  logic             acq_start_q, rst_n_q, busy_q, done_q;

  logic [CNT_W-1:0] rst_eff, acq_eff, gap_eff;
  logic signed [CNT_W:0] gap_diff;
  logic             cfg_ld, cnt_ld, cnt_tc, more_win;
  logic [CNT_W-1:0] cnt_val;

  // Gap is computed once at start; a non-positive difference still leaves one low cycle.
  always_comb begin
    rst_eff  = (rst_len == '0) ? CNT_W'(1) : rst_len;
    acq_eff  = (acq_len == '0) ? CNT_W'(1) : acq_len;
    gap_diff = $signed({1'b0, echo_period}) - $signed({1'b0, acq_eff});
    gap_eff  = (!gap_diff[CNT_W] && (gap_diff != '0)) ? gap_diff[CNT_W-1:0] : CNT_W'(1);
  end

  assign more_win = ((NUM_W+1)'(idx_q) + (NUM_W+1)'(1)) < (NUM_W+1)'(num_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cfg_ld  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_d = ST_RST;
          cfg_ld  = 1'b1;
          idx_d   = '0;
          cnt_ld  = 1'b1;
          cnt_val = rst_eff;
        end
        ST_RST: if (cnt_tc) begin
          if (pre_q != '0) begin
            state_d = ST_PRE;
            cnt_ld  = 1'b1;
            cnt_val = pre_q;
          end else if (num_q == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ACQ;
            cnt_ld  = 1'b1;
            cnt_val = acq_q;
          end
        end
        ST_PRE: if (cnt_tc) begin
          if (num_q == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ACQ;
            cnt_ld  = 1'b1;
            cnt_val = acq_q;
          end
        end
        ST_ACQ: if (cnt_tc) begin
          if (more_win) begin
            state_d = ST_GAP;
            cnt_ld  = 1'b1;
            cnt_val = gap_q;
          end else begin
            state_d = ST_FIN;
          end
        end
        ST_GAP: if (cnt_tc) begin
          state_d = ST_ACQ;
          idx_d   = idx_q + NUM_W'(1);
          cnt_ld  = 1'b1;
          cnt_val = acq_q;
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      acq_q       <= CNT_W'(1);
      gap_q       <= CNT_W'(1);
      num_q       <= '0;
      idx_q       <= '0;
      acq_start_q <= 1'b0;
      rst_n_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cfg_ld) begin
        pre_q <= pre_dly;
        acq_q <= acq_eff;
        gap_q <= gap_eff;
        num_q <= echo_num;
      end
      acq_start_q <= (state_d == ST_ACQ);
      rst_n_q     <= (state_d != ST_RST);
      busy_q      <= (state_d == ST_RST) || (state_d == ST_PRE) ||
                     (state_d == ST_ACQ) || (state_d == ST_GAP);
      done_q      <= (state_d == ST_FIN);
    end
  end

  seq_cnt #(.W(CNT_W)) u_cnt (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_val),
    .en_i     (state_q != ST_IDLE),
    .tc_o     (cnt_tc)
  );

  assign n_acq_start = acq_start_q;
  assign n_rst_n     = rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign echo_idx    = idx_q;

endmodule

// File: tb/tb_n_acq_seq.sv
// Directed bench for n_acq_seq: table of configs with hand-computed timing,
// plus abort, reset, start-while-busy and start+abort corner sequences.
module tb_n_acq_seq;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] rst_len, pre_dly, acq_len, echo_period;
  logic [11:0] echo_num;
  logic        n_acq_start, n_rst_n, busy, done;
  logic [11:0] echo_idx;

  int errs = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  n_acq_seq dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .rst_len     (rst_len),
    .pre_dly     (pre_dly),
    .acq_len     (acq_len),
    .echo_period (echo_period),
    .echo_num    (echo_num),
    .n_acq_start (n_acq_start),
    .n_rst_n     (n_rst_n),
    .busy        (busy),
    .done        (done),
    .echo_idx    (echo_idx)
  );

  // exp_*: reset-low length, first window cycle, effective period, window length,
  // window count and done cycle, all relative to the start cycle.
  typedef struct {
    logic [15:0] rl, pd, al, ep;
    logic [11:0] en;
    int exp_r, exp_w0, exp_per, exp_a, exp_n, exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", name, t, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int stop_t, input int restart_t);
    int last;
    int k, ph;
    logic e_acq;
    int e_idx;
    last = (stop_t > 0) ? stop_t : v.exp_done + 2;
    @(negedge clk_sys);
    rst_len = v.rl; pre_dly = v.pd; acq_len = v.al; echo_period = v.ep; echo_num = v.en;
    start = 1'b1;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk_sys);
      e_acq = 1'b0;
      e_idx = 0;
      if (v.exp_n > 0 && t >= v.exp_w0) begin
        k  = (t - v.exp_w0) / v.exp_per;
        ph = (t - v.exp_w0) % v.exp_per;
        e_acq = (k < v.exp_n) && (ph < v.exp_a);
        e_idx = (k < v.exp_n) ? k : v.exp_n - 1;
      end
      chk("n_rst_n", t, n_rst_n, !(t <= v.exp_r));
      chk("busy", t, busy, (t < v.exp_done));
      chk("done", t, done, (t == v.exp_done));
      chk("n_acq_start", t, n_acq_start, e_acq);
      chk("echo_idx", t, echo_idx, e_idx);
      start = (t == restart_t);
      if (t == 1) begin
        rst_len = 16'd7; pre_dly = 16'd0; acq_len = 16'd1; echo_period = 16'd2; echo_num = 12'd9;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_idle(input string name, input int t);
    chk({name, "_acq"}, t, n_acq_start, 1'b0);
    chk({name, "_busy"}, t, busy, 1'b0);
    chk({name, "_done"}, t, done, 1'b0);
    chk({name, "_rstn"}, t, n_rst_n, 1'b1);
  endtask

  initial begin
    //          rl  pd  al  ep   en  R  W0 per A  N  done
    vecs[0] = '{16'd3, 16'd5, 16'd4, 16'd10, 12'd3, 3, 9, 10, 4, 3, 33};
    vecs[1] = '{16'd2, 16'd0, 16'd4, 16'd10, 12'd0, 2, 0, 1, 1, 0, 3};
    vecs[2] = '{16'd1, 16'd0, 16'd6, 16'd4, 12'd2, 1, 2, 7, 6, 2, 15};
    vecs[3] = '{16'd0, 16'd2, 16'd0, 16'd3, 12'd3, 1, 4, 3, 1, 3, 11};
    vecs[4] = '{16'd1, 16'd4, 16'd2, 16'd5, 12'd0, 1, 0, 1, 1, 0, 6};
    vecs[5] = '{16'd1, 16'd0, 16'd3, 16'd3, 12'd2, 1, 2, 4, 3, 2, 9};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    rst_len = '0; pre_dly = '0; acq_len = '0; echo_period = '0; echo_num = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_acq", 0, n_acq_start, 1'b0);
    chk("rst_rstn", 0, n_rst_n, 1'b0);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_done", 0, done, 1'b0);
    chk("rst_idx", 0, echo_idx, 0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk_idle("post_rst", 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], -1, -1);

    // start and abort together in IDLE: start dropped
    @(negedge clk_sys);
    rst_len = 16'd3; pre_dly = 16'd5; acq_len = 16'd4; echo_period = 16'd10; echo_num = 12'd3;
    start = 1'b1; abort = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; abort = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      chk_idle("st_ab", t);
      @(negedge clk_sys);
    end

    // abort during window 1 of 3
    run_vec(vecs[0], 20, -1);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    chk_idle("abort", 21);
    for (int t = 22; t <= 40; t++) begin
      @(negedge clk_sys);
      chk("abort_nodone", t, done, 1'b0);
      chk("abort_nobusy", t, busy, 1'b0);
    end
    run_vec(vecs[1], -1, -1);

    // second start while busy is ignored
    run_vec(vecs[0], -1, 5);

    // synchronous reset in the middle of window 1
    run_vec(vecs[0], 20, -1);
    rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    chk("mid_rst_acq", 21, n_acq_start, 1'b0);
    chk("mid_rst_rstn", 21, n_rst_n, 1'b0);
    chk("mid_rst_busy", 21, busy, 1'b0);
    chk("mid_rst_done", 21, done, 1'b0);
    chk("mid_rst_idx", 21, echo_idx, 0);
    @(negedge clk_sys);
    chk_idle("post_mid_rst", 22);
    run_vec(vecs[3], -1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
